// File: rtl/sa_writer_pkg.sv
// Shared types and constants for the systolic-array result writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sa_writer_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int DATA_W_DEF  = 8;
    localparam int NUM_RESULTS = 4;
    localparam int IDX_W       = $clog2(NUM_RESULTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sa_result_writer_if.sv
// RAM write port shared with the top-level address/data mux.
// Latency: combinational bundle.
// Backpressure: grant from the mux gates every write.
interface sa_result_writer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              grant;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (input grant, output we, output addr, output data);
    modport slave  (output grant, input we, input addr, input data);
endinterface

// File: rtl/sa_result_buffer.sv
// Four-entry capture register file for the 2x2 array results; SA_WRITER_RELU_EN clamps negatives to 0 on load.
// Latency: one cycle from load strobe to readable entry; read port is combinational.
// Backpressure: none; a load overwrites all entries.
module sa_result_buffer
    import sa_writer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_i,
    input  logic [NUM_RESULTS-1:0][DATA_W-1:0] ld_dat_i,
    input  logic [IDX_W-1:0]                   rd_idx_i,
    output logic [DATA_W-1:0]                  rd_dat_o
);

    logic [DATA_W-1:0] entry_q [NUM_RESULTS];
    logic [DATA_W-1:0] entry_d [NUM_RESULTS];

    function automatic logic [DATA_W-1:0] cond_relu(input logic [DATA_W-1:0] v);
`ifdef SA_WRITER_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_RESULTS; i++) begin
            entry_d[i] = entry_q[i];
            if (load_i) begin
                entry_d[i] = cond_relu(ld_dat_i[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign rd_dat_o = entry_q[rd_idx_i];

endmodule

// File: rtl/sa_result_writer.sv
// Captures the 2x2 array results on en and writes them to RAM at base..base+3 (mod 2^ADDR_W).
// Latency: writes in cycles 1..4 after the en edge, is_done_o in cycle 5 with grant held high.
// Backpressure: grant=0 stalls the current write with addr/data held; en outside IDLE is ignored.
module sa_result_writer
    import sa_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ADDR_W-1:0]   result_baseaddr,
    input  logic [DATA_W-1:0]   c11,
    input  logic [DATA_W-1:0]   c12,
    input  logic [DATA_W-1:0]   c21,
    input  logic [DATA_W-1:0]   c22,
    sa_result_writer_if.master  wr,
    output logic                busy_o,
    output logic                is_done_o
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              load;
    logic [DATA_W-1:0] rd_dat;

    sa_result_buffer #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .ld_dat_i ({c22, c21, c12, c11}),
        .rd_idx_i (idx_q),
        .rd_dat_o (rd_dat)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        load      = 1'b0;
        wr.we     = 1'b0;
        wr.addr   = '0;
        wr.data   = '0;
        busy_o    = 1'b0;
        is_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    load    = 1'b1;
                    base_d  = result_baseaddr;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy_o  = 1'b1;
                wr.we   = wr.grant;
                // Adder width matches the RAM address so the write window wraps.
                wr.addr = base_q + ADDR_W'(idx_q);
                wr.data = rd_dat;
                if (wr.grant) begin
                    if (idx_q == IDX_W'(NUM_RESULTS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                is_done_o = 1'b1;
                idx_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_sa_result_writer.sv
// Scoreboard bench for sa_result_writer: directed jobs push expected (cycle, addr, data) writes and done cycles.
module tb_sa_result_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [5:0] result_baseaddr = '0;
    logic [7:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic       busy_o, is_done_o;

    sa_result_writer_if #(.ADDR_W(6), .DATA_W(8)) wr_if ();

    sa_result_writer #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .result_baseaddr (result_baseaddr),
        .c11             (c11),
        .c12             (c12),
        .c21             (c21),
        .c22             (c22),
        .wr              (wr_if.master),
        .busy_o          (busy_o),
        .is_done_o       (is_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  n_chk = 0;
    int  n_pass = 0;

    task automatic chk(input bit ok, input string nm, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", nm, detail);
    endtask

    function automatic logic [7:0] exp_val(input logic [7:0] v);
`ifdef SA_WRITER_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: every write and done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (wr_if.we) begin
            if (wq.size() == 0) begin
                chk(1'b0, "unexpected_write",
                    $sformatf("got addr=%0d data=%h at cyc %0d, expected none", wr_if.addr, wr_if.data, cyc));
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk(e.cyc == cyc && e.addr == wr_if.addr && e.data == wr_if.data, "write",
                    $sformatf("got cyc=%0d addr=%0d data=%h, expected cyc=%0d addr=%0d data=%h",
                              cyc, wr_if.addr, wr_if.data, e.cyc, e.addr, e.data));
            end
        end else if (busy_o && wq.size() > 0) begin
            chk(wr_if.addr == wq[0].addr && wr_if.data == wq[0].data, "stall_hold",
                $sformatf("got addr=%0d data=%h, expected addr=%0d data=%h",
                          wr_if.addr, wr_if.data, wq[0].addr, wq[0].data));
        end
        if (is_done_o) begin
            if (dq.size() == 0) begin
                chk(1'b0, "unexpected_done", $sformatf("got done at cyc %0d, expected none", cyc));
            end else begin
                int d;
                d = dq.pop_front();
                chk(d == cyc, "done_cycle", $sformatf("got cyc=%0d, expected cyc=%0d", cyc, d));
            end
        end
    end

    task automatic push_write(input int c, input logic [5:0] a, input logic [7:0] d);
        wr_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    task automatic check_idle(input string nm);
        @(negedge clk);
        chk(wq.size() == 0 && dq.size() == 0, {nm, "_drain"},
            $sformatf("got %0d writes and %0d dones outstanding, expected 0", wq.size(), dq.size()));
        chk(!busy_o, {nm, "_idle"}, $sformatf("got busy_o=%b, expected 0", busy_o));
    endtask

    // stall bit p drops grant during period p after the start edge.
    task automatic do_job(input string nm, input logic [5:0] base,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3,
                          input logic [9:0] stall, input bit inject);
        logic [7:0] d[4];
        int         c0;
        int         k;
        d = '{d0, d1, d2, d3};
        @(posedge clk); #1;
        en = 1'b1;
        result_baseaddr = base;
        c11 = d0; c12 = d1; c21 = d2; c22 = d3;
        wr_if.grant = 1'b1;
        c0 = cyc + 1;
        k = 0;
        for (int p = 0; p < 10; p++) begin
            if (k < 4 && !stall[p]) begin
                push_write(c0 + p, base + 6'(k), exp_val(d[k]));
                k++;
                if (k == 4) dq.push_back(c0 + p + 1);
            end
        end
        for (int p = 0; p < 10; p++) begin
            @(posedge clk); #1;
            en = 1'b0;
            wr_if.grant = !stall[p];
            if (inject && p == 1) begin
                en = 1'b1;
                c11 = ~d0; c12 = ~d1; c21 = ~d2; c22 = ~d3;
                result_baseaddr = base + 6'd20;
            end
        end
        wr_if.grant = 1'b1;
        check_idle(nm);
    endtask

    initial begin
        int c0;
        wr_if.grant = 1'b0;
        #3;
        chk(wr_if.we == 1'b0, "rst_we", $sformatf("got %b, expected 0", wr_if.we));
        chk(busy_o == 1'b0, "rst_busy", $sformatf("got %b, expected 0", busy_o));
        chk(is_done_o == 1'b0, "rst_done", $sformatf("got %b, expected 0", is_done_o));
        chk(wr_if.addr == 6'd0, "rst_addr", $sformatf("got %0d, expected 0", wr_if.addr));
        chk(wr_if.data == 8'd0, "rst_data", $sformatf("got %h, expected 00", wr_if.data));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_job("basic", 6'd5, 8'h11, 8'h22, 8'h33, 8'h44, 10'b0, 1'b0);
        do_job("stall", 6'd5, 8'h11, 8'h22, 8'h33, 8'h44, 10'b10, 1'b0);
        do_job("wrap", 6'd62, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 10'b0, 1'b0);
        do_job("capture", 6'd7, 8'h01, 8'h02, 8'h03, 8'h04, 10'b0, 1'b1);

        // Reset after the second write commits: remaining writes and the done pulse are dropped.
        @(posedge clk); #1;
        en = 1'b1;
        result_baseaddr = 6'd20;
        c11 = 8'h55; c12 = 8'h66; c21 = 8'h77; c22 = 8'h08;
        wr_if.grant = 1'b1;
        c0 = cyc + 1;
        push_write(c0, 6'd20, exp_val(8'h55));
        push_write(c0 + 1, 6'd21, exp_val(8'h66));
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk(wr_if.we == 1'b0, "midrst_we", $sformatf("got %b, expected 0", wr_if.we));
        chk(busy_o == 1'b0, "midrst_busy", $sformatf("got %b, expected 0", busy_o));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) @(posedge clk);
        check_idle("midrst");
        do_job("after_rst", 6'd10, 8'h21, 8'h32, 8'h43, 8'h54, 10'b0, 1'b0);

        do_job("relu", 6'd0, 8'hF3, 8'h7F, 8'h80, 8'h01, 10'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/sa_result_writer.md
Name: sa_result_writer

Overview:
- Write-back end of the systolic-array data path. It captures the four 8-bit results of the 2x2 array (c11, c12, c21, c22) and writes them sequentially into the single-port RAM, starting at a programmable base address.
- It is the RAM write-side counterpart of the feature loader and weight preloader, which only read.
- RAM access is gated by a grant from the top-level address/data mux, so reads and writes never overlap.

Parameters:
- ADDR_W, 6, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, width of one result word and of a RAM word.
- NUM_RESULTS, 4, number of results written per job (fixed at 4 for the 2x2 array).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  start pulse; sampled only in IDLE.
- result_baseaddr  in  ADDR_W  first write address; latched at start.
- c11  in  DATA_W  array result (0,0).
- c12  in  DATA_W  array result (0,1).
- c21  in  DATA_W  array result (1,0).
- c22  in  DATA_W  array result (1,1).
- grant  in  1  RAM write port granted this cycle.
- addr  out  ADDR_W  RAM write address.
- data  out  DATA_W  RAM write data.
- we  out  1  RAM write enable.
- busy_o  out  1  job in progress (state WRITE).
- is_done_o  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, idx=0, base register=0, all four buffer entries=0.
  - Outputs: we=0, busy_o=0, is_done_o=0, addr=0, data=0.
- States are IDLE, WRITE and DONE.
- IDLE:
  - When en=1 at a rising edge, latch c11, c12, c21, c22 into buffer entries 0..3 and latch result_baseaddr.
  - Set idx=0 and go to WRITE.
  - With en=0, remain in IDLE.
- WRITE:
  - Outputs are combinational from registers: we=grant; addr=base+idx, truncated to ADDR_W; data=buf[idx].
  - On an edge with grant=1: if idx=NUM_RESULTS-1, go to DONE; otherwise idx increments.
  - On an edge with grant=0: stall. idx and state hold, and addr/data stay stable.
- DONE: is_done_o=1 for exactly one cycle, then unconditionally return to IDLE, with idx=0.
- Outside WRITE: we=0, addr=0, data=0.
- Latency: with grant held at 1, the en edge is at cycle 0, writes occur in cycles 1..4, and is_done_o is high in cycle 5. Each grant=0 cycle adds one cycle.
- en while busy_o=1 or in DONE is ignored; a new job can start on the edge that leaves DONE only if it is re-sampled in IDLE.
- c11..c22 changing after the start edge has no effect, because the values are captured.
- Address wrap: base=62 gives writes at addresses 62, 63, 0, 1.
- Reset mid-job: an immediate return to IDLE with we=0. There is no partial-completion pulse, and any remaining writes are lost.
- Write order is c11, c12, c21, c22 (row-major).

Optional Feature:
- Macro: SA_WRITER_RELU_EN.
- Defined: each result is treated as signed two's complement at capture time; a value with MSB=1 is stored as 0, otherwise unchanged (e.g. 8'hF3 is written as 8'h00, 8'h12 as 8'h12).
- Undefined: results are written bit-exact as captured.

Decomposition:
- Shared package sa_writer_pkg contains:
  - the state enum (IDLE, WRITE, DONE);
  - the ADDR_W and DATA_W defaults;
  - the NUM_RESULTS constant.
- Sub-module sa_result_buffer: a 4-entry DATA_W capture register file. It has a load strobe, four parallel inputs, an index read port, and the optional ReLU applied on load.
- The FSM, index counter and address adder stay in sa_result_writer.

Test Plan:
- Reset, then en=1 with base=5, c11..c22=8'h11/8'h22/8'h33/8'h44 and grant=1 → writes (5,11), (6,22), (7,33), (8,44) in cycles 1..4; is_done_o high in cycle 5 only.
- Same job with grant=0 in cycle 2 only → write to address 6 occurs in cycle 3; addr/data held during the stall; is_done_o moves to cycle 6.
- base=62 → writes at addresses 62, 63, 0, 1; no write to 2.
- Change c11..c22 and pulse en during WRITE → written data equals the values captured at start; no second job starts.
- rst asserted low after the second write → we=0 immediately; is_done_o never pulses; a new en with base=10 writes 10..13 normally.
- SA_WRITER_RELU_EN defined, inputs 8'hF3/8'h7F/8'h80/8'h01 → written 00/7F/00/01; with the macro undefined → F3/7F/80/01.
